// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Constants shared by the fetch, decode and hazard stages of
//               the five-stage core: datapath width, the canonical NOP
//               encoding, instruction size and the default reset vector.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Datapath width for PC and instruction words
    localparam int          C_XLEN       = 32;

    // addi x0, x0, 0 : the bubble placed into IF/ID on reset and on flush
    localparam logic [31:0] C_NOP_INST   = 32'h0000_0013;

    // Byte distance between sequential instructions
    localparam int          C_INST_BYTES = 4;

    // Default PC loaded on reset (word aligned)
    localparam logic [31:0] C_RESET_ADDR = 32'h0000_0000;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Captures the fetched instruction and
//               its PC. Reset and flush both load a NOP bubble; the enable
//               holds the current contents when low.
//               Priority: rst > flush > enable.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int          XLEN     = C_XLEN,
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inst,
    output logic            o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            r_valid;

    // Load a bubble on reset/flush, otherwise capture the fetch when enabled
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pc    <= '0;
            r_inst  <= XLEN'(NOP_INST);
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Holds the PC, drives the instruction
//               memory address and feeds the IF/ID register. Honours the
//               hazard unit's PC_En / IF_ID_En stalls and EX-stage redirects.
//               Per-cycle priority: rst > redirect > stall > advance.
//               Optional macro FETCH_PERF_EN adds fetch/stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = C_RESET_ADDR,
    parameter int          XLEN       = C_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PC_En,
    input  logic            IF_ID_En,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_inst,
    output logic            valid_inst,
    output logic [XLEN-1:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush
`endif
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~(XLEN'(C_INST_BYTES - 1));

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_redirect_target;

    // Low address bits of the target are forced to zero so the PC stays word aligned
    assign w_redirect_target = redirect_pc & c_ALIGN_MASK;

    // Next-PC select: redirect beats a stall, advance wraps naturally
    always_comb begin
        w_pc_next = r_pc;
        if (redirect) begin
            w_pc_next = w_redirect_target;
        end else if (PC_En) begin
            w_pc_next = r_pc + XLEN'(C_INST_BYTES);
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= XLEN'(RESET_ADDR);
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // imem address comes straight from the PC register, no input feedthrough
    assign imem_addr = r_pc;
    assign pc        = r_pc;

    // A redirect flushes the wrong-path word even if IF/ID is stalled
    if_id_reg #(
        .XLEN     (XLEN),
        .NOP_INST (C_NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_en    (IF_ID_En),
        .i_flush (redirect),
        .i_pc    (r_pc),
        .i_inst  (imem_rdata),
        .o_pc    (if_id_pc),
        .o_inst  (if_id_inst),
        .o_valid (valid_inst)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Event counters: valid IF/ID loads, PC stalls and redirect flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (!redirect && IF_ID_En) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (!redirect && !PC_En) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
`endif

endmodule : fetch_stage
`default_nettype wire
